// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount greedily as quarter, dime and
// nickel eject pulses, one coin at a time, with an optional idle gap between
// coins. All outputs come straight from registers.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int AMOUNT_W     = 6
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                start,
  input  logic [AMOUNT_W-1:0] amount,
  output logic                busy,
  output logic                ejectq,
  output logic                ejectd,
  output logic                ejectn,
  output logic [AMOUNT_W-1:0] remaining,
  output logic                done,
  output logic                err
);

  // One counter serves both the pulse and the gap timing, so it is sized for
  // the longer of the two.
  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [AMOUNT_W-1:0] Q_VAL = AMOUNT_W'(25);
  localparam logic [AMOUNT_W-1:0] D_VAL = AMOUNT_W'(10);
  localparam logic [AMOUNT_W-1:0] N_VAL = AMOUNT_W'(5);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  // Eject vector is one-hot {quarter, dime, nickel} or all zero.
  localparam logic [2:0] EJ_Q = 3'b100;
  localparam logic [2:0] EJ_D = 3'b010;
  localparam logic [2:0] EJ_N = 3'b001;

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [AMOUNT_W-1:0] rem_reg, rem_next;
  logic [2:0]          eject_reg, eject_next;
  logic                err_reg, err_next;
  logic                done_reg, done_next;
  logic                busy_reg, busy_next;

  // State and output registers; reset clears everything immediately, so a
  // coin in flight simply stops being driven.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      eject_reg <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      eject_reg <= eject_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state logic; output registers are loaded with the value they must
  // show in the state being entered.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    eject_next = eject_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          rem_next   = amount;
          err_next   = 1'b0;
          state_next = SELECT;
        end
      end
      SELECT: begin
        // Largest coin that still fits; the guard makes underflow impossible.
        if (rem_reg >= Q_VAL) begin
          eject_next = EJ_Q;
          rem_next   = rem_reg - Q_VAL;
          cnt_next   = PULSE_LOAD;
          state_next = PULSE;
        end else if (rem_reg >= D_VAL) begin
          eject_next = EJ_D;
          rem_next   = rem_reg - D_VAL;
          cnt_next   = PULSE_LOAD;
          state_next = PULSE;
        end else if (rem_reg >= N_VAL) begin
          eject_next = EJ_N;
          rem_next   = rem_reg - N_VAL;
          cnt_next   = PULSE_LOAD;
          state_next = PULSE;
        end else begin
          err_next   = (rem_reg != '0);
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          eject_next = '0;
          if (GAP_CYCLES == 0) begin
            state_next = SELECT;
          end else begin
            cnt_next   = GAP_LOAD;
            state_next = GAP;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = SELECT;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        eject_next = '0;
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  assign busy      = busy_reg;
  assign ejectq    = eject_reg[2];
  assign ejectd    = eject_reg[1];
  assign ejectn    = eject_reg[0];
  assign remaining = rem_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: instance a uses P=4,G=2 and instance
// b uses P=1,G=0. Expected per-cycle waveforms come from the coin list and
// the pulse/gap timing of each transaction.
module tb_change_dispenser;

  logic       clk;
  logic       rst_a, start_a, rst_b, start_b;
  logic [5:0] amount_a, amount_b;
  logic       busy_a, q_a, d_a, n_a, done_a, err_a;
  logic       busy_b, q_b, d_b, n_b, done_b, err_b;
  logic [5:0] rem_a, rem_b;

  int total = 0;
  int bad   = 0;

  change_dispenser #(.PULSE_CYCLES(4), .GAP_CYCLES(2), .AMOUNT_W(6)) dut_a (
    .clkin(clk), .reset(rst_a), .start(start_a), .amount(amount_a),
    .busy(busy_a), .ejectq(q_a), .ejectd(d_a), .ejectn(n_a),
    .remaining(rem_a), .done(done_a), .err(err_a)
  );

  change_dispenser #(.PULSE_CYCLES(1), .GAP_CYCLES(0), .AMOUNT_W(6)) dut_b (
    .clkin(clk), .reset(rst_b), .start(start_b), .amount(amount_b),
    .busy(busy_b), .ejectq(q_b), .ejectd(d_b), .ejectn(n_b),
    .remaining(rem_b), .done(done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int coin_val(input logic [2:0] c);
    case (c)
      3'b100:  return 25;
      3'b010:  return 10;
      3'b001:  return 5;
      default: return 0;
    endcase
  endfunction

  // Runs one transaction on the selected instance from an idle negedge.
  // coins holds up to three one-hot {Q,D,N} codes, coin i at bits [3i+:3].
  // inj >= 0 re-pulses Start with Amount=25 before edge inj+1.
  task automatic run_txn(input bit sel, input string tag, input int amt,
                         input int p, input int g, input int k,
                         input logic [8:0] coins, input int inj, input int fin_err);
    int t, last, exp_rem, done_n;
    logic [2:0] exp_ej, c;
    t      = 1 + p + g;
    done_n = k * t + 1;
    last   = done_n + 2;
    if (sel) begin start_b = 1'b1; amount_b = 6'(amt); end
    else     begin start_a = 1'b1; amount_a = 6'(amt); end
    @(negedge clk);
    for (int n = 0; n <= last; n++) begin
      exp_ej  = 3'b000;
      exp_rem = amt;
      for (int i = 0; i < k; i++) begin
        c = coins[3*i +: 3];
        if (n >= 1 + i*t && n <= i*t + p) exp_ej = c;
        if (n >= 1 + i*t) exp_rem -= coin_val(c);
      end
      chk($sformatf("%s_eject_n%0d", tag, n), sel ? {q_b, d_b, n_b} : {q_a, d_a, n_a}, exp_ej);
      chk($sformatf("%s_rem_n%0d", tag, n), sel ? rem_b : rem_a, exp_rem);
      chk($sformatf("%s_busy_n%0d", tag, n), sel ? busy_b : busy_a, (n <= done_n) ? 1 : 0);
      chk($sformatf("%s_done_n%0d", tag, n), sel ? done_b : done_a, (n == done_n) ? 1 : 0);
      chk($sformatf("%s_err_n%0d", tag, n), sel ? err_b : err_a, (n >= done_n) ? fin_err : 0);
      if (sel) start_b = 1'b0;
      else if (n == inj) begin start_a = 1'b1; amount_a = 6'd25; end
      else start_a = 1'b0;
      @(negedge clk);
    end
    $display("txn %s amount=%0d coins=%0d rem=%0d err=%0d", tag, amt, k,
             sel ? rem_b : rem_a, sel ? err_b : err_a);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    amount_a = '0; amount_b = '0;
    #1;
    chk("reset_busy", busy_a, 0);
    chk("reset_eject", {q_a, d_a, n_a}, 0);
    chk("reset_rem", rem_a, 0);
    chk("reset_done_err", {done_a, err_a}, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_a, 0);

    // 40 -> Q, D, N with Remaining 15, 5, 0; Done after edge 22.
    run_txn(0, "t1_amt40", 40, 4, 2, 3, {3'b001, 3'b010, 3'b100}, -1, 0);

    // 63 -> Q, Q, D leaving 3 unpaid; Err set and held in IDLE.
    run_txn(0, "t2_amt63", 63, 4, 2, 3, {3'b010, 3'b100, 3'b100}, -1, 1);
    repeat (3) @(negedge clk);
    chk("t2_err_hold", err_a, 1);
    chk("t2_rem_hold", rem_a, 3);
    chk("t2_busy_idle", busy_a, 0);

    // 0 -> no coins, Done after edge 1, Err cleared by the new Start.
    run_txn(0, "t3_amt0", 0, 4, 2, 0, 9'd0, -1, 0);

    // Start with 25 during the first Q pulse is ignored.
    run_txn(0, "t4_restart", 40, 4, 2, 3, {3'b001, 3'b010, 3'b100}, 2, 0);
    repeat (3) @(negedge clk);
    chk("t4_no_extra_coin", {q_a, d_a, n_a, busy_a}, 0);
    chk("t4_rem_hold", rem_a, 0);

    // Reset in the middle of a quarter pulse.
    start_a = 1'b1; amount_a = 6'd40;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_pre_reset_q", q_a, 1);
    rst_a = 1'b1;
    #1;
    chk("t5_async_eject", {q_a, d_a, n_a}, 0);
    chk("t5_async_busy", busy_a, 0);
    chk("t5_async_rem", rem_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("t5_idle_after", {busy_a, done_a, err_a}, 0);
    run_txn(0, "t5_amt10", 10, 4, 2, 1, {6'd0, 3'b010}, -1, 0);

    // P=1, G=0: two Q pulses one SELECT apart, Done after edge 5.
    run_txn(1, "t6_amt50", 50, 1, 0, 2, {3'b000, 3'b100, 3'b100}, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
